// File: rtl/i2c_master_byte_if.sv
// i2c_master_byte_if
// ------------------
// Bundles the command handshake, the result signals and the open-drain pin
// controls of i2c_master_byte into one interface.
//
// Handshake: a command is taken on a rising clk edge where cmd_valid=1 and
// cmd_ready=1. cmd, wdata and rd_nack are captured on that same edge and may
// change freely afterwards. cmd_ready is high only while the master is idle.
// done pulses for one cycle when the command finishes. err, rdata and ack_rx
// are valid from the done pulse onwards.
//
// Modports:
//   master - the byte-level I2C master (drives results and pin enables)
//   slave  - the host side plus the sensed pins (drives commands and scl_in/sda_in)
//
// Signals:
//   cmd_valid  host requests a command
//   cmd_ready  master idle; command accepted when cmd_valid=1
//   cmd        00 START, 01 STOP, 10 WRITE, 11 READ
//   wdata      byte to send for WRITE
//   rd_nack    READ: level sent in the 9th bit (1 = NACK)
//   done       one-cycle completion pulse
//   rdata      last READ result
//   ack_rx     last WRITE acknowledge bit (0 = ACK)
//   err        command was illegal in the current bus state (valid with done)
//   bus_owned  set by START, cleared by STOP
//   scl_oe     1 = pull SCL low
//   sda_oe     1 = pull SDA low
//   scl_in     synchronised SCL pin level
//   sda_in     synchronised SDA pin level
interface i2c_master_byte_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;
    logic [7:0] wdata;
    logic       rd_nack;
    logic       done;
    logic [7:0] rdata;
    logic       ack_rx;
    logic       err;
    logic       bus_owned;
    logic       scl_oe;
    logic       sda_oe;
    logic       scl_in;
    logic       sda_in;

    modport master (
        input  cmd_valid, cmd, wdata, rd_nack, scl_in, sda_in,
        output cmd_ready, done, rdata, ack_rx, err, bus_owned, scl_oe, sda_oe
    );

    modport slave (
        output cmd_valid, cmd, wdata, rd_nack, scl_in, sda_in,
        input  cmd_ready, done, rdata, ack_rx, err, bus_owned, scl_oe, sda_oe
    );
endinterface

// File: rtl/i2c_master_byte.sv
// i2c_master_byte
// ---------------
// Byte-oriented single-master I2C engine. Executes one command at a time:
// START / repeated START, STOP, WRITE byte, READ byte. SCL is generated from a
// quarter-period divider and the slave may stretch the clock. Both lines are
// driven open-drain through output enables.
//
// Parameters:
//   CLK_DIV  clk cycles per SCL quarter period (>= 2)
//   CNT_W    width of the quarter counter
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset; releases both lines at once
//   bus        i2c_master_byte_if.master (command handshake, results, pins)
//   state_dbg  current FSM state (IDLE=0, START=1, BIT=2, STOP=3, FIN=4)
//
// Every bus operation is a run of quarters Q0..Q3. Pin enables change on the
// edge that enters a quarter, so they are registered and glitch free.
module i2c_master_byte #(
    parameter int CLK_DIV = 16,
    parameter int CNT_W   = $clog2(CLK_DIV)
) (
    input  logic              clk,
    input  logic              rst,
    i2c_master_byte_if.master bus,
    output logic [2:0]        state_dbg
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_BIT   = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [2:0]       state;
    logic [1:0]       q;          // current quarter
    logic [CNT_W-1:0] cnt;        // cycle within the quarter
    logic [3:0]       bit_idx;    // 0..8, bit 8 is the acknowledge slot
    logic [1:0]       cmd_r;
    logic [7:0]       sh;         // WRITE: outgoing bits at [7]; READ: incoming bits at [0]
    logic             rd_nack_r;
    logic             ack_bit;
    logic             err_r;

    logic             scl_oe_q;
    logic             sda_oe_q;
    logic             done_q;
    logic             err_q;
    logic [7:0]       rdata_q;
    logic             ack_rx_q;
    logic             bus_owned_q;

    logic             busy;
    logic             stretch;
    logic             q_end;

    // Stretching: while SCL is released the quarter cannot start counting
    // until the pin is really high, so a slave holding it low freezes the
    // counter at 0 for exactly as many cycles as it holds.
    always_comb begin
        busy    = (state == ST_START) || (state == ST_BIT) || (state == ST_STOP);
        stretch = busy && !scl_oe_q && !bus.scl_in && (cnt == '0);
        q_end   = busy && !stretch && (cnt == CNT_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            q           <= 2'd0;
            cnt         <= '0;
            bit_idx     <= 4'd0;
            cmd_r       <= CMD_START;
            sh          <= 8'h00;
            rd_nack_r   <= 1'b0;
            ack_bit     <= 1'b1;
            err_r       <= 1'b0;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 8'h00;
            ack_rx_q    <= 1'b1;
            bus_owned_q <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (busy && !stretch) begin
                cnt <= q_end ? '0 : cnt + 1'b1;
            end
            if (q_end) begin
                q <= q + 2'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        cmd_r     <= bus.cmd;
                        sh        <= bus.wdata;
                        rd_nack_r <= bus.rd_nack;
                        q         <= 2'd0;
                        cnt       <= '0;
                        bit_idx   <= 4'd0;
                        if ((bus.cmd != CMD_START) && !bus_owned_q) begin
                            // Nothing to talk to without owning the bus:
                            // report the error without touching the pins.
                            err_r <= 1'b1;
                            state <= ST_FIN;
                        end else begin
                            err_r <= 1'b0;
                            case (bus.cmd)
                                CMD_START: begin
                                    // Q0: release SDA; SCL keeps its level so a
                                    // repeated START sees SDA rise while SCL is low.
                                    state    <= ST_START;
                                    sda_oe_q <= 1'b0;
                                end
                                CMD_STOP: begin
                                    state    <= ST_STOP;
                                    scl_oe_q <= 1'b1;
                                    sda_oe_q <= 1'b1;
                                end
                                default: begin
                                    // First data bit, MSB first. READ leaves SDA to the slave.
                                    state    <= ST_BIT;
                                    scl_oe_q <= 1'b1;
                                    sda_oe_q <= (bus.cmd == CMD_WRITE) ? ~bus.wdata[7] : 1'b0;
                                end
                            endcase
                        end
                    end
                end

                ST_START: begin
                    if (q_end) begin
                        case (q)
                            2'd0:    scl_oe_q <= 1'b0;  // SCL up (may stretch)
                            2'd1:    sda_oe_q <= 1'b1;  // SDA falls with SCL high
                            2'd2:    scl_oe_q <= 1'b1;  // SCL down, ready for data
                            default: state    <= ST_FIN;
                        endcase
                    end
                end

                ST_STOP: begin
                    if (q_end) begin
                        case (q)
                            2'd0:    scl_oe_q <= 1'b0;  // SCL up (may stretch)
                            2'd1:    sda_oe_q <= 1'b0;  // SDA rises with SCL high
                            2'd2:    ;                  // bus-free hold
                            default: state    <= ST_FIN;
                        endcase
                    end
                end

                ST_BIT: begin
                    if (q_end) begin
                        case (q)
                            2'd0: ;
                            2'd1: scl_oe_q <= 1'b0;
                            2'd2: begin
                                // Sample on the last cycle of the high phase that
                                // precedes Q3, after any stretch has ended.
                                if (bit_idx == 4'd8) begin
                                    if (cmd_r == CMD_WRITE) begin
                                        ack_bit <= bus.sda_in;
                                    end
                                end else begin
                                    sh <= {sh[6:0], bus.sda_in};
                                end
                            end
                            default: begin
                                // SCL falls here for the next bit, or for FIN.
                                scl_oe_q <= 1'b1;
                                if (bit_idx == 4'd8) begin
                                    state <= ST_FIN;
                                end else begin
                                    bit_idx <= bit_idx + 4'd1;
                                    if (bit_idx == 4'd7) begin
                                        // Acknowledge slot: WRITE listens, READ answers.
                                        sda_oe_q <= (cmd_r == CMD_WRITE) ? 1'b0 : ~rd_nack_r;
                                    end else begin
                                        sda_oe_q <= (cmd_r == CMD_WRITE) ? ~sh[7] : 1'b0;
                                    end
                                end
                            end
                        endcase
                    end
                end

                ST_FIN: begin
                    // Results and bus ownership update together with done.
                    state  <= ST_IDLE;
                    done_q <= 1'b1;
                    err_q  <= err_r;
                    if (!err_r) begin
                        case (cmd_r)
                            CMD_START: bus_owned_q <= 1'b1;
                            CMD_STOP:  bus_owned_q <= 1'b0;
                            CMD_WRITE: ack_rx_q    <= ack_bit;
                            default:   rdata_q     <= sh;
                        endcase
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state == ST_IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.ack_rx    = ack_rx_q;
    assign bus.bus_owned = bus_owned_q;
    assign bus.scl_oe    = scl_oe_q;
    assign bus.sda_oe    = sda_oe_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_i2c_master_byte.sv
// Testbench for i2c_master_byte with CLK_DIV=4.
// A small slave model drives SDA for reads and acknowledges, and can stretch SCL.
module tb_i2c_master_byte;
    localparam int CLK_DIV = 4;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    i2c_master_byte_if bus();
    logic [2:0] state_dbg;

    i2c_master_byte #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    int checks   = 0;
    int failures = 0;

    // slave / bus model
    int         slave_mode = 0;      // 0 passive, 1 ACK writes, 2 return slave_byte on reads
    logic [7:0] slave_byte = 8'h00;
    logic       stretch_arm = 1'b0;
    int         cmd_gen = 0;

    logic       slave_hold = 1'b0;
    int         scnt = 0;
    int         mon_gen = 0;
    int         idx = 0;             // SCL falls since the current command was issued
    int         nrise = 0;
    int         n_start = 0;
    int         n_stop = 0;
    logic [8:0] rise_sda = '0;       // [8] = first bit
    logic [8:0] rise_oe = '0;
    logic       oe_any = 1'b0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;

    logic [7:0] sb_shift;
    logic       slave_pull;
    always_comb begin
        sb_shift   = slave_byte << idx;
        slave_pull = 1'b0;
        if (slave_mode == 2 && idx < 8) slave_pull = !sb_shift[7];
        if (slave_mode == 1 && idx == 8) slave_pull = 1'b1;
    end

    assign bus.scl_in = !(bus.scl_oe || slave_hold);
    assign bus.sda_in = !(bus.sda_oe || slave_pull);

    // bus monitor and clock stretcher, sampled on the falling edge
    always @(negedge clk) begin
        if (mon_gen != cmd_gen) begin
            mon_gen  = cmd_gen;
            idx      = 0;
            nrise    = 0;
            n_start  = 0;
            n_stop   = 0;
            rise_sda = '0;
            rise_oe  = '0;
            oe_any   = 1'b0;
        end
        if (prev_scl && !bus.scl_in) idx++;
        if (!prev_scl && bus.scl_in) begin
            if (nrise < 9) begin
                rise_sda[8-nrise] = bus.sda_in;
                rise_oe[8-nrise]  = bus.sda_oe;
            end
            nrise++;
        end
        if (bus.scl_in && prev_scl && prev_sda && !bus.sda_in) n_start++;
        if (bus.scl_in && prev_scl && !prev_sda && bus.sda_in) n_stop++;
        if (bus.scl_oe || bus.sda_oe) oe_any = 1'b1;
        prev_scl = bus.scl_in;
        prev_sda = bus.sda_in;
        if (stretch_arm && !slave_hold && scnt == 0 && idx == 3 && bus.scl_oe) begin
            slave_hold = 1'b1;
        end else if (slave_hold && !bus.scl_oe) begin
            scnt++;
            if (scnt == 11) slave_hold = 1'b0;
        end
    end

    // driver: issue one command and count cycles from accept to done
    task automatic do_cmd(input logic [1:0] c, input logic [7:0] wd, input logic nk, output int lat);
        int guard;
        guard = 0;
        while (!bus.cmd_ready && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.cmd       = c;
        bus.wdata     = wd;
        bus.rd_nack   = nk;
        bus.cmd_valid = 1'b1;
        cmd_gen++;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        lat = 0;
        while (lat < 1000) begin
            @(posedge clk); #1;
            lat++;
            if (bus.done) break;
        end
        if (!bus.done) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd = 2'b00;
        bus.wdata = 8'h00;
        bus.rd_nack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.scl_oe, bus.sda_oe, bus.done, bus.err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_lines: got %b expected 0000", {bus.scl_oe, bus.sda_oe, bus.done, bus.err});
        end
        checks++;
        if (bus.rdata !== 8'h00 || bus.ack_rx !== 1'b1 || bus.bus_owned !== 1'b0) begin
            failures++;
            $display("FAIL reset_results: rdata=%h ack_rx=%b bus_owned=%b expected 00 1 0", bus.rdata, bus.ack_rx, bus.bus_owned);
        end
        checks++;
        if (bus.cmd_ready !== 1'b1 || state_dbg !== 3'd0) begin
            failures++;
            $display("FAIL reset_idle: cmd_ready=%b state=%0d expected 1 0", bus.cmd_ready, state_dbg);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.scl_oe !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: cmd_ready=%b scl_oe=%b expected 1 0", bus.cmd_ready, bus.scl_oe);
        end
    endtask

    task automatic test_unowned();
        int lat;
        do_cmd(2'b10, 8'hA5, 1'b0, lat);
        checks++;
        if (lat !== 1 || bus.err !== 1'b1) begin
            failures++;
            $display("FAIL unowned_write: lat=%0d err=%b expected 1 1", lat, bus.err);
        end
        checks++;
        if (oe_any !== 1'b0 || bus.bus_owned !== 1'b0) begin
            failures++;
            $display("FAIL unowned_pins: oe_any=%b bus_owned=%b expected 0 0", oe_any, bus.bus_owned);
        end
        do_cmd(2'b01, 8'h00, 1'b0, lat);
        checks++;
        if (lat !== 1 || bus.err !== 1'b1 || oe_any !== 1'b0) begin
            failures++;
            $display("FAIL unowned_stop: lat=%0d err=%b oe_any=%b expected 1 1 0", lat, bus.err, oe_any);
        end
        do_cmd(2'b11, 8'h00, 1'b1, lat);
        checks++;
        if (lat !== 1 || bus.err !== 1'b1) begin
            failures++;
            $display("FAIL unowned_read: lat=%0d err=%b expected 1 1", lat, bus.err);
        end
    endtask

    task automatic test_start(input string name);
        int lat;
        slave_mode = 0;
        do_cmd(2'b00, 8'h00, 1'b0, lat);
        checks++;
        if (lat !== 17) begin
            failures++;
            $display("FAIL %s_latency: got %0d expected 17", name, lat);
        end
        checks++;
        if (bus.err !== 1'b0 || bus.bus_owned !== 1'b1 || n_start !== 1) begin
            failures++;
            $display("FAIL %s_state: err=%b bus_owned=%b starts=%0d expected 0 1 1", name, bus.err, bus.bus_owned, n_start);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0 || bus.scl_oe !== 1'b1) begin
            failures++;
            $display("FAIL %s_after: done=%b scl_oe=%b expected 0 1", name, bus.done, bus.scl_oe);
        end
    endtask

    task automatic test_write(input string name, input logic [7:0] wd, input int mode, input logic stretch,
                              input int exp_lat, input logic exp_ack);
        int lat;
        slave_mode  = mode;
        stretch_arm = stretch;
        do_cmd(2'b10, wd, 1'b0, lat);
        stretch_arm = 1'b0;
        checks++;
        if (lat !== exp_lat || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL %s_latency: lat=%0d err=%b expected %0d 0", name, lat, bus.err, exp_lat);
        end
        checks++;
        if (rise_sda[8:1] !== wd || nrise !== 9) begin
            failures++;
            $display("FAIL %s_bits: sda=%h rises=%0d expected %h 9", name, rise_sda[8:1], nrise, wd);
        end
        checks++;
        if (rise_oe[0] !== 1'b0 || bus.ack_rx !== exp_ack) begin
            failures++;
            $display("FAIL %s_ack: oe9=%b ack_rx=%b expected 0 %b", name, rise_oe[0], bus.ack_rx, exp_ack);
        end
    endtask

    task automatic test_read(input string name, input logic [7:0] sb, input logic nk, input logic [7:0] prev_rdata,
                             input logic [8:0] exp_oe);
        int lat;
        slave_mode = 2;
        slave_byte = sb;
        checks++;
        if (bus.rdata !== prev_rdata) begin
            failures++;
            $display("FAIL %s_rdata_held: got %h expected %h", name, bus.rdata, prev_rdata);
        end
        do_cmd(2'b11, 8'h00, nk, lat);
        checks++;
        if (lat !== 145 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL %s_latency: lat=%0d err=%b expected 145 0", name, lat, bus.err);
        end
        checks++;
        if (bus.rdata !== sb) begin
            failures++;
            $display("FAIL %s_rdata: got %h expected %h", name, bus.rdata, sb);
        end
        checks++;
        if (rise_oe !== exp_oe || nrise !== 9) begin
            failures++;
            $display("FAIL %s_sda_oe: got %b rises=%0d expected %b 9", name, rise_oe, nrise, exp_oe);
        end
        slave_mode = 0;
    endtask

    task automatic test_stop();
        int lat;
        slave_mode = 0;
        do_cmd(2'b01, 8'h00, 1'b0, lat);
        checks++;
        if (lat !== 17 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL stop_latency: lat=%0d err=%b expected 17 0", lat, bus.err);
        end
        checks++;
        if (bus.bus_owned !== 1'b0 || n_stop !== 1 || bus.scl_oe !== 1'b0 || bus.sda_oe !== 1'b0) begin
            failures++;
            $display("FAIL stop_state: bus_owned=%b stops=%0d scl_oe=%b sda_oe=%b expected 0 1 0 0",
                     bus.bus_owned, n_stop, bus.scl_oe, bus.sda_oe);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        int lat;
        test_start("rstmid_start");
        slave_mode    = 0;
        bus.cmd       = 2'b10;
        bus.wdata     = 8'h00;
        bus.rd_nack   = 1'b0;
        bus.cmd_valid = 1'b1;
        cmd_gen++;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        guard = 0;
        while (idx != 5 && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (idx !== 5 || bus.scl_oe !== 1'b1 || bus.sda_oe !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_reach: idx=%0d scl_oe=%b sda_oe=%b expected 5 1 1", idx, bus.scl_oe, bus.sda_oe);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.scl_oe !== 1'b0 || bus.sda_oe !== 1'b0 || bus.bus_owned !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async: scl_oe=%b sda_oe=%b bus_owned=%b expected 0 0 0", bus.scl_oe, bus.sda_oe, bus.bus_owned);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0 || state_dbg !== 3'd0) begin
            failures++;
            $display("FAIL rstmid_release: cmd_ready=%b done=%b state=%0d expected 1 0 0", bus.cmd_ready, bus.done, state_dbg);
        end
        do_cmd(2'b01, 8'h00, 1'b0, lat);
        checks++;
        if (lat !== 1 || bus.err !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_stop_err: lat=%0d err=%b expected 1 1", lat, bus.err);
        end
    endtask

    initial begin
        test_reset();
        test_unowned();
        test_start("start");
        test_write("write_a5", 8'hA5, 1, 1'b0, 145, 1'b0);
        test_read("read_3c", 8'h3C, 1'b1, 8'h00, 9'b000000000);
        test_read("read_ack", 8'hC3, 1'b0, 8'h3C, 9'b000000001);
        test_write("write_nack", 8'h5A, 0, 1'b0, 145, 1'b1);
        test_write("write_stretch", 8'h96, 1, 1'b1, 155, 1'b0);
        test_start("rep_start");
        test_stop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
